// File: rtl/lz_norm_pkg.sv
// Shared widths and the exponent/shift-amount rule for the 16-bit normalizer.
package lz_norm_pkg;

    localparam int MANT_W        = 16;
    localparam int LZ_W          = 4;
    localparam int DEFAULT_EXP_W = 8;
    // Wide enough for any instantiated exponent width; callers truncate the result.
    localparam int CALC_EXP_W    = 32;

    typedef struct packed {
        logic [LZ_W-1:0]       shamt;
        logic [CALC_EXP_W-1:0] exp_out;
        logic                  zero;
        logic                  uf;
    } norm_ctl_t;

    function automatic norm_ctl_t calc_shamt(
        input logic [CALC_EXP_W-1:0] exp_in,
        input logic                  lz_valid,
        input logic [LZ_W-1:0]       lz_pos
    );
        norm_ctl_t r;
        r = '0;
        if (!lz_valid) begin
            r.zero = 1'b1;
        end else if (CALC_EXP_W'(lz_pos) < exp_in) begin
            r.shamt   = lz_pos;
            r.exp_out = exp_in - CALC_EXP_W'(lz_pos);
        end else begin
            // exp_in <= lz_pos <= 15 here, so its low bits are the full shift.
            r.shamt = exp_in[LZ_W-1:0];
            r.uf    = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lz_shift16.sv
// Combinational 4-level logarithmic left shifter, zero-filled.
module lz_shift16
    import lz_norm_pkg::*;
(
    input  logic [MANT_W-1:0] din,
    input  logic [LZ_W-1:0]   shamt,
    output logic [MANT_W-1:0] dout
);

    logic [MANT_W-1:0] lvl8;
    logic [MANT_W-1:0] lvl4;
    logic [MANT_W-1:0] lvl2;

    assign lvl8 = shamt[3] ? {din[7:0],   8'h00} : din;
    assign lvl4 = shamt[2] ? {lvl8[11:0], 4'h0}  : lvl8;
    assign lvl2 = shamt[1] ? {lvl4[13:0], 2'b00} : lvl4;
    assign dout = shamt[0] ? {lvl2[14:0], 1'b0}  : lvl2;

endmodule

// File: rtl/lz_normalizer16.sv
// Two-stage normalizer: S1 computes shift/exponent/flags, S2 applies the shift.
module lz_normalizer16
    import lz_norm_pkg::*;
#(
    parameter int EXP_W = DEFAULT_EXP_W,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_lz_valid,
    input  logic [LZ_W-1:0]   in_lz_pos,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_zero,
    output logic              out_underflow
);

    logic              s1_valid, s1_zero, s1_uf;
    logic [MANT_W-1:0] s1_mant;
    logic [LZ_W-1:0]   s1_shamt;
    logic [EXP_W-1:0]  s1_exp;
    logic [TAG_W-1:0]  s1_tag;

    logic              s2_valid, s2_zero, s2_uf;
    logic [MANT_W-1:0] s2_mant;
    logic [EXP_W-1:0]  s2_exp;
    logic [TAG_W-1:0]  s2_tag;

    logic              s1_adv, s2_adv;
    logic [MANT_W-1:0] shifted;
    norm_ctl_t         ctl;

    // Handshake: a beat moves when valid & ready are both high at the rising edge;
    // a stage loads when it is empty or its contents move on in the same cycle.
    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv && !rst;

    assign ctl = calc_shamt(CALC_EXP_W'(in_exp), in_lz_valid, in_lz_pos);

    lz_shift16 u_shift (
        .din   (s1_mant),
        .shamt (s1_shamt),
        .dout  (shifted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mant  <= '0;
            s1_shamt <= '0;
            s1_exp   <= '0;
            s1_tag   <= '0;
            s1_zero  <= 1'b0;
            s1_uf    <= 1'b0;
            s2_valid <= 1'b0;
            s2_mant  <= '0;
            s2_exp   <= '0;
            s2_tag   <= '0;
            s2_zero  <= 1'b0;
            s2_uf    <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_mant  <= ctl.zero ? '0 : in_mant;
                    s1_shamt <= ctl.shamt;
                    s1_exp   <= EXP_W'(ctl.exp_out);
                    s1_tag   <= in_tag;
                    s1_zero  <= ctl.zero;
                    s1_uf    <= ctl.uf;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_mant <= shifted;
                    s2_exp  <= s1_exp;
                    s2_tag  <= s1_tag;
                    s2_zero <= s1_zero;
                    s2_uf   <= s1_uf;
                end
            end
        end
    end

    assign out_valid     = s2_valid;
    assign out_mant      = s2_mant;
    assign out_exp       = s2_exp;
    assign out_tag       = s2_tag;
    assign out_zero      = s2_zero;
    assign out_underflow = s2_uf;

endmodule

// File: tb/tb_lz_normalizer16.sv
// Bench for lz_normalizer16: directed vectors, stall/order, reset and randomized traffic.
module tb_lz_normalizer16;

    localparam int EXP_W = 8;
    localparam int TAG_W = 4;
    localparam int RW    = 16 + EXP_W + TAG_W + 2;
    localparam int N_RAND = 10000;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_mant;
    logic [EXP_W-1:0] in_exp;
    logic             in_lz_valid;
    logic [3:0]       in_lz_pos;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_mant;
    logic [EXP_W-1:0] out_exp;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;
    logic             out_underflow;

    logic [RW-1:0]    obs;
    logic [RW-1:0]    exp_q[$];
    int               total = 0;
    int               bad   = 0;

    assign obs = {out_mant, out_exp, out_tag, out_zero, out_underflow};

    lz_normalizer16 #(.EXP_W(EXP_W), .TAG_W(TAG_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_mant       (in_mant),
        .in_exp        (in_exp),
        .in_lz_valid   (in_lz_valid),
        .in_lz_pos     (in_lz_pos),
        .in_tag        (in_tag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_mant      (out_mant),
        .out_exp       (out_exp),
        .out_tag       (out_tag),
        .out_zero      (out_zero),
        .out_underflow (out_underflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: value semantics of a normalized result
    function automatic logic [3:0] count_lz(input logic [15:0] m);
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) return 4'(15 - i);
        end
        return 4'd0;
    endfunction

    function automatic logic [RW-1:0] ref_item(input logic [15:0] mant, input logic [EXP_W-1:0] e,
                                               input logic lzv, input logic [3:0] lzp,
                                               input logic [TAG_W-1:0] tag);
        logic [31:0]      w;
        logic [EXP_W-1:0] eo;
        logic             uf;
        int               k;
        if (!lzv) return {16'h0000, {EXP_W{1'b0}}, tag, 1'b1, 1'b0};
        if (int'(lzp) < int'(e)) begin
            k  = int'(lzp);
            eo = EXP_W'(int'(e) - int'(lzp));
            uf = 1'b0;
        end else begin
            k  = int'(e);
            eo = '0;
            uf = 1'b1;
        end
        w = {16'h0000, mant} << k;
        return {w[15:0], eo, tag, 1'b0, uf};
    endfunction

    // drivers
    task automatic drive(input logic v, input logic [15:0] m, input logic [EXP_W-1:0] e,
                         input logic lzv, input logic [3:0] lzp, input logic [TAG_W-1:0] t);
        in_valid    = v;
        in_mant     = m;
        in_exp      = e;
        in_lz_valid = lzv;
        in_lz_pos   = lzp;
        in_tag      = t;
    endtask

    task automatic drive_idle();
        drive(1'b0, 16'h0000, '0, 1'b0, 4'd0, '0);
    endtask

    task automatic drive_random(input logic [TAG_W-1:0] t);
        logic [15:0]      m;
        logic [EXP_W-1:0] e;
        m = 16'($urandom) >> $urandom_range(0, 16);
        e = ($urandom_range(0, 3) == 0) ? EXP_W'($urandom_range(0, 16)) : EXP_W'($urandom_range(0, 255));
        if (m == 16'h0000) drive(1'b1, m, e, 1'b0, 4'($urandom_range(0, 15)), t);
        else               drive(1'b1, m, e, 1'b1, count_lz(m), t);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 16'h0F00, 8'd20, 1'b1, 4'd4, 4'd9);
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        total++;
        if (obs !== '0) begin
            bad++; $display("FAIL reset_out_data: got %h want 0", obs);
        end
        rst = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_no_accept: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_directed();
        logic [15:0]      mants[4] = '{16'h0F00, 16'h0000, 16'h0010, 16'h0001};
        logic [EXP_W-1:0] exps[4]  = '{8'd20, 8'd50, 8'd5, 8'd15};
        logic             lzvs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [3:0]       poss[4]  = '{4'd4, 4'd0, 4'd11, 4'd15};
        logic [RW-1:0]    want[4]  = '{{16'hF000, 8'd16, 4'd1, 2'b00},
                                       {16'h0000, 8'd0,  4'd2, 2'b10},
                                       {16'h0200, 8'd0,  4'd3, 2'b01},
                                       {16'h8000, 8'd0,  4'd4, 2'b01}};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b1, mants[i], exps[i], lzvs[i], poss[i], 4'(i + 1));
            #1;
            total++;
            if (in_ready !== 1'b1) begin
                bad++; $display("FAIL directed%0d_in_ready: got %b want 1", i, in_ready);
            end
            @(negedge clk);
            drive_idle();
            total++;
            if (out_valid !== 1'b0) begin
                bad++; $display("FAIL directed%0d_early: got out_valid=%b want 0", i, out_valid);
            end
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || obs !== want[i]) begin
                bad++; $display("FAIL directed%0d_result: got v=%b %h want v=1 %h", i, out_valid, obs, want[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int            sent = 0;
        int            got  = 0;
        int            occ  = 0;
        logic          held = 1'b0;
        logic [RW-1:0] held_obs = '0;
        logic          want_ready;
        logic [RW-1:0] e;
        exp_q.delete();
        for (int c = 1; c <= 40 && got < 6; c++) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 6);
            if (sent < 6) drive_random(4'(sent + 1));
            else          drive_idle();
            #1;
            if (held) begin
                total++;
                if (out_valid !== 1'b1 || obs !== held_obs) begin
                    bad++; $display("FAIL b2b_stall_stable c%0d: got v=%b %h want v=1 %h", c, out_valid, obs, held_obs);
                end
            end
            want_ready = (occ < 2) || out_ready;
            total++;
            if (in_ready !== want_ready) begin
                bad++; $display("FAIL b2b_in_ready c%0d: got %b want %b", c, in_ready, want_ready);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_item(in_mant, in_exp, in_lz_valid, in_lz_pos, in_tag));
                sent++;
                occ++;
            end
            if (out_valid && out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                total++;
                if (obs !== e) begin
                    bad++; $display("FAIL b2b_item%0d: got %h want %h", got, obs, e);
                end
                got++;
                occ--;
            end
            held     = out_valid && !out_ready;
            held_obs = obs;
        end
        drive_idle();
        out_ready = 1'b1;
        total++;
        if (got != 6) begin
            bad++; $display("FAIL b2b_count: got %0d items want 6", got);
        end
    endtask

    task automatic test_reset_mid();
        logic [RW-1:0] e;
        out_ready = 1'b0;
        @(negedge clk);
        drive(1'b1, 16'h00F0, 8'd40, 1'b1, 4'd8, 4'd10);
        @(negedge clk);
        drive(1'b1, 16'h0300, 8'd40, 1'b1, 4'd6, 4'd11);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 16'h0800, 8'd30, 1'b1, 4'd4, 4'd12);
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL rstmid_in_ready: got %b want 0", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 16'h0081, 8'd30, 1'b1, 4'd8, 4'd13);
        e = ref_item(16'h0081, 8'd30, 1'b1, 4'd8, 4'd13);
        #1;
        total++;
        if (out_valid !== 1'b0 || obs !== '0) begin
            bad++; $display("FAIL rstmid_flushed: got v=%b %h want v=0 0", out_valid, obs);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL rstmid_ready_after: got %b want 1", in_ready);
        end
        @(negedge clk);
        drive_idle();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL rstmid_early: got out_valid=%b want 0", out_valid);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || obs !== e) begin
            bad++; $display("FAIL rstmid_next_item: got v=%b %h want v=1 %h", out_valid, obs, e);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL rstmid_no_dup: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_random();
        int            n_in  = 0;
        int            n_out = 0;
        logic [RW-1:0] e;
        exp_q.delete();
        for (int c = 0; c < 60000 && n_out < N_RAND; c++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            if (n_in < N_RAND && $urandom_range(0, 4) != 0) drive_random(TAG_W'($urandom));
            else                                             drive_idle();
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_item(in_mant, in_exp, in_lz_valid, in_lz_pos, in_tag));
                n_in++;
            end
            if (out_valid && out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                total++;
                if (obs !== e) begin
                    bad++; $display("FAIL rand_item%0d: got %h want %h", n_out, obs, e);
                end
                if (!out_zero && !out_underflow) begin
                    total++;
                    if (out_mant[15] !== 1'b1) begin
                        bad++; $display("FAIL rand_msb%0d: got mant=%h want msb 1", n_out, out_mant);
                    end
                end
                n_out++;
            end
        end
        drive_idle();
        total++;
        if (n_out != N_RAND) begin
            bad++; $display("FAIL rand_count: got %0d items want %0d", n_out, N_RAND);
        end
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        drive_idle();
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
